// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sampler.
// The channel-mask helper keeps unscanned frame bits at zero.
package mux_scan_pkg;

   localparam int SEL_W   = 3;
   localparam int FRAME_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      WAIT
   } state_t;

   function automatic logic [FRAME_W-1:0] ch_mask(input int num_ch);
      logic [FRAME_W-1:0] m;
      m = '0;
      for (int i = 0; i < FRAME_W; i++) begin
         if (i < num_ch) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while enabled and wraps to 0.
// done flags the final cycle of the current dwell window.
module dwell_timer #(
   parameter int CNT_W = 8,
   parameter int DWELL = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= done ? '0 : cnt + 1'b1;
      end
   end

   assign done = (cnt == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// Walks the mux select across the channels, samples each channel after its
// dwell window, and offers the assembled frame on a valid/ready handshake.
module mux_scan_sampler
   import mux_scan_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DWELL  = 3,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               cont,
   input  logic               abort,
   output logic [SEL_W-1:0]   mux_sel,
   input  logic               mux_out,
   output logic [FRAME_W-1:0] frame_data,
   output logic               frame_valid,
   input  logic               frame_ready,
   output logic               busy
);

   localparam int                 LAST_CH  = NUM_CH - 1;
   localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(LAST_CH);
   localparam logic [FRAME_W-1:0] CH_MASK  = ch_mask(NUM_CH);

   state_t             state;
   logic [FRAME_W-1:0] shadow;
   logic [FRAME_W-1:0] merged;
   logic               dwell_done;
   logic               timer_clr;
   logic               timer_en;

   // The timer only runs in SCAN; every entry into SCAN therefore sees cnt=0.
   assign timer_en  = (state == SCAN);
   assign timer_clr = abort || (state != SCAN);

   dwell_timer #(
      .CNT_W (CNT_W),
      .DWELL (DWELL)
   ) u_dwell_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (timer_clr),
      .en   (timer_en),
      .done (dwell_done)
   );

   always_comb begin
      merged = shadow;
      merged[mux_sel[1:0]] = mux_out;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mux_sel     <= '0;
         shadow      <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
      end else if (abort) begin
         state       <= IDLE;
         shadow      <= '0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SCAN;
                  mux_sel <= '0;
                  shadow  <= '0;
                  busy    <= 1'b1;
               end
            end
            SCAN: begin
               if (dwell_done) begin
                  shadow <= merged;
                  if (mux_sel == LAST_SEL) begin
                     frame_data  <= merged & CH_MASK;
                     frame_valid <= 1'b1;
                     state       <= WAIT;
                  end else begin
                     mux_sel <= mux_sel + 1'b1;
                  end
               end
            end
            WAIT: begin
               // Frame is held here until accepted; nothing rescans meanwhile.
               if (frame_ready) begin
                  frame_valid <= 1'b0;
                  if (cont) begin
                     state   <= SCAN;
                     mux_sel <= '0;
                     shadow  <= '0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
